// File: rtl/fp_exp_unit_pipe.sv
// Two-stage exponent datapath for the FP divider/multiplier.
// Produces saturated biased exponents, range flags and ovf/unf counters.
module fp_exp_unit_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127,
  parameter int CNT_W = 16,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf,
  output logic             unf,
  output logic             a_spec,
  output logic             b_spec,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam logic [EXP_W+1:0] BIAS_X = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX =
    (EXP_W+2)'((1 << EXP_W) - 1);

  logic             s1_valid_q, s1_valid_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic             op_q, op_d;
  logic             as1_q, as1_d, bs1_q, bs1_d;

  logic             s2_valid_q, s2_valid_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             as2_q, as2_d, bs2_q, bs2_d;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

  logic [EXP_W-1:0] ea, eb;
  logic [EXP_W+1:0] r;
  logic             r_ovf, r_unf;
  logic             adv, s1_load, xfer;
  logic             unused_bits;

  assign unused_bits = ^{in1[W-1], in1[MAN_W-1:0],
                         in2[W-1], in2[MAN_W-1:0]};

  always_comb begin
    ea      = in1[W-2 -: EXP_W];
    eb      = in2[W-2 -: EXP_W];
    adv     = !s2_valid_q || out_ready;
    s1_load = !s1_valid_q || adv;
    xfer    = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    op_d       = op_q;
    as1_d      = as1_q;
    bs1_d      = bs1_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      ea_d       = (ea == '0) ? EXP_W'(1) : ea;
      eb_d       = (eb == '0) ? EXP_W'(1) : eb;
      op_d       = op;
      as1_d      = &ea;
      bs1_d      = &eb;
    end

    // Two extra bits hold the full signed range of both operations.
    if (op_q)
      r = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_X;
    else
      r = {2'b00, ea_q} - {2'b00, eb_q} + BIAS_X;
    r_ovf = $signed(r) >= EMAX;
    r_unf = $signed(r) <= 0;

    s2_valid_d = s2_valid_q;
    exp_d      = exp_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    as2_d      = as2_q;
    bs2_d      = bs2_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      ovf_d      = r_ovf;
      unf_d      = r_unf;
      as2_d      = as1_q;
      bs2_d      = bs1_q;
      if (r_ovf)      exp_d = '1;
      else if (r_unf) exp_d = '0;
      else            exp_d = r[EXP_W-1:0];
    end

    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (clr_cnt) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (xfer && ovf_q && ovf_cnt_q != '1)
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (xfer && unf_q && unf_cnt_q != '1)
        unf_cnt_d = unf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      op_q       <= 1'b0;
      as1_q      <= 1'b0;
      bs1_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      exp_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      as2_q      <= 1'b0;
      bs2_q      <= 1'b0;
      ovf_cnt_q  <= '0;
      unf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      op_q       <= op_d;
      as1_q      <= as1_d;
      bs1_q      <= bs1_d;
      s2_valid_q <= s2_valid_d;
      exp_q      <= exp_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      as2_q      <= as2_d;
      bs2_q      <= bs2_d;
      ovf_cnt_q  <= ovf_cnt_d;
      unf_cnt_q  <= unf_cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign exp_out   = exp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign a_spec    = as2_q;
  assign b_spec    = bs2_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

endmodule
